// File: rtl/timer_service_pkg.sv
// Shared definitions for the hardware interval-timer service master:
// timer register map, control-word encodings and the sequencer state type.
package timer_service_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    // 0x0007: interrupt enable + continuous + start; 0x0008: stop
    localparam logic [15:0] CMD_START = (16'd1 << CTRL_ITO) | (16'd1 << CTRL_CONT) | (16'd1 << CTRL_START);
    localparam logic [15:0] CMD_STOP  = (16'd1 << CTRL_STOP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_PL,
        S_W_PH,
        S_W_CTRL,
        S_WAIT_IRQ,
        S_W_STAT,
        S_W_SNAP,
        S_R_SL,
        S_R_SH,
        S_CAP_H,
        S_DONE,
        S_W_STOP
    } state_t;

endpackage

// File: rtl/timer_service_master.sv
// Avalon-MM initiator that programs and services the interval timer in hardware,
// publishing a snapshot and a running tick count on every timer interrupt.
module timer_service_master
    import timer_service_pkg::*;
#(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd99999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_period,
    input  logic        irq,
    input  logic [15:0] av_readdata,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    output logic        running,
    output logic [31:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid
);

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        stop_pend_q, stop_pend_d;
    logic [15:0] lo_q, lo_d;
    logic        running_q, running_d;
    logic [31:0] tick_q, tick_d;
    logic [31:0] snap_q, snap_d;
    logic        valid_q, valid_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wd_q, wd_d;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        stop_pend_d = stop_pend_q;
        lo_d        = lo_q;
        running_d   = running_q;
        tick_d      = tick_q;
        snap_d      = snap_q;
        valid_d     = 1'b0;

        if (stop && state_q != S_IDLE) stop_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    period_d = (cfg_period == '0) ? PERIOD_DEFAULT : cfg_period;
                    state_d  = S_W_PL;
                end
            end
            S_W_PL:   state_d = S_W_PH;
            S_W_PH:   state_d = S_W_CTRL;
            S_W_CTRL: begin
                state_d   = S_WAIT_IRQ;
                running_d = 1'b1;
            end
            S_WAIT_IRQ: begin
                // A stop arriving in this very cycle still beats a coincident irq
                if (stop_pend_q || stop) state_d = S_W_STOP;
                else if (irq)            state_d = S_W_STAT;
            end
            S_W_STAT: state_d = S_W_SNAP;
            S_W_SNAP: state_d = S_R_SL;
            S_R_SL:   state_d = S_R_SH;
            S_R_SH: begin
                lo_d    = av_readdata;
                state_d = S_CAP_H;
            end
            S_CAP_H: begin
                snap_d  = {av_readdata, lo_q};
                tick_d  = tick_q + 32'd1;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:   state_d = S_WAIT_IRQ;
            S_W_STOP: begin
                state_d     = S_IDLE;
                running_d   = 1'b0;
                stop_pend_d = 1'b0;
            end
            default:  state_d = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they register in step with it
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = '0;
        wd_d   = '0;
        case (state_d)
            S_W_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_L; wd_d = period_d[15:0];  end
            S_W_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_H; wd_d = period_d[31:16]; end
            S_W_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;  wd_d = CMD_START;       end
            S_W_STAT: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;                           end
            S_W_SNAP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SNAP_L;                           end
            S_R_SL:   begin cs_d = 1'b1;              addr_d = ADDR_SNAP_L;                           end
            S_R_SH:   begin cs_d = 1'b1;              addr_d = ADDR_SNAP_H;                           end
            S_W_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;  wd_d = CMD_STOP;        end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            stop_pend_q <= 1'b0;
            lo_q        <= '0;
            running_q   <= 1'b0;
            tick_q      <= '0;
            snap_q      <= '0;
            valid_q     <= 1'b0;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            stop_pend_q <= stop_pend_d;
            lo_q        <= lo_d;
            running_q   <= running_d;
            tick_q      <= tick_d;
            snap_q      <= snap_d;
            valid_q     <= valid_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
        end
    end

    assign av_chipselect = cs_q;
    assign av_write_n    = wn_q;
    assign av_address    = addr_q;
    assign av_writedata  = wd_q;
    assign running       = running_q;
    assign tick_count    = tick_q;
    assign snap_value    = snap_q;
    assign snap_valid    = valid_q;

endmodule
